// File: rtl/pio_irq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pio_irq_ctrl : shared PIO IRQ flag register with overflow tracking and
//                two masked system interrupt lines.
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module pio_irq_ctrl #(
   parameter int NUM_SM    = 4,
   parameter int NUM_FLAGS = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_SM-1:0]           sm_valid,
   input  logic [NUM_SM*NUM_FLAGS-1:0] sm_set,
   input  logic [NUM_SM*NUM_FLAGS-1:0] sm_clr,
   input  logic                        host_clr_wr,
   input  logic [NUM_FLAGS-1:0]        host_clr_data,
   input  logic                        host_force_wr,
   input  logic [NUM_FLAGS-1:0]        host_force_data,
   input  logic                        host_ovf_clr_wr,
   input  logic [NUM_FLAGS-1:0]        host_ovf_clr_data,
   input  logic [3:0]                  irq0_en,
   input  logic [3:0]                  irq1_en,
   output logic [NUM_FLAGS-1:0]        flags,
   output logic [NUM_FLAGS-1:0]        overflow,
   output logic                        irq0,
   output logic                        irq1
);

   localparam int SYS_FLAGS = 4;

   logic [NUM_FLAGS-1:0] set_any;
   logic [NUM_FLAGS-1:0] clr_any;
   logic [NUM_FLAGS-1:0] set_seen;
   logic [NUM_FLAGS-1:0] set_multi;
   logic [NUM_FLAGS-1:0] flags_next;
   logic [NUM_FLAGS-1:0] overflow_next;

   // set_multi marks bits hit by two or more set sources in the same cycle
   always_comb begin
      set_seen  = host_force_wr ? host_force_data : '0;
      set_multi = '0;
      clr_any   = host_clr_wr ? host_clr_data : '0;
      for (int i = 0; i < NUM_SM; i++) begin
         if (sm_valid[i]) begin
            set_multi = set_multi | (set_seen & sm_set[i*NUM_FLAGS +: NUM_FLAGS]);
            set_seen  = set_seen | sm_set[i*NUM_FLAGS +: NUM_FLAGS];
            clr_any   = clr_any | sm_clr[i*NUM_FLAGS +: NUM_FLAGS];
         end
      end
      set_any = set_seen;
   end

   // Set wins over clear, and a fresh overflow wins over the host clear
   always_comb begin
      flags_next    = (flags & ~clr_any) | set_any;
      overflow_next = overflow & ~(host_ovf_clr_wr ? host_ovf_clr_data : '0);
      overflow_next = overflow_next | (set_any & flags) | set_multi;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         flags    <= '0;
         overflow <= '0;
         irq0     <= 1'b0;
         irq1     <= 1'b0;
      end else begin
         flags    <= flags_next;
         overflow <= overflow_next;
         irq0     <= |(flags_next[SYS_FLAGS-1:0] & irq0_en);
         irq1     <= |(flags_next[SYS_FLAGS-1:0] & irq1_en);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pio_irq_ctrl.sv
`default_nettype none
// tb_pio_irq_ctrl : directed bench with a per-bit behavioural model compared
// every cycle, plus literal expectations from hand calculation.
module tb_pio_irq_ctrl;
   localparam int NSM = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [NSM-1:0] sm_valid;
   logic [NSM*8-1:0] sm_set, sm_clr;
   logic           host_clr_wr, host_force_wr, host_ovf_clr_wr;
   logic [7:0]     host_clr_data, host_force_data, host_ovf_clr_data;
   logic [3:0]     irq0_en, irq1_en;
   logic [7:0]     flags, overflow;
   logic           irq0, irq1;

   int tests = 0;
   int fails = 0;
   logic chk_on = 1'b0;

   logic [7:0] exp_flags = '0, exp_ovf = '0;
   logic       exp_irq0 = 1'b0, exp_irq1 = 1'b0;

   pio_irq_ctrl #(.NUM_SM(NSM), .NUM_FLAGS(8)) dut (
      .clk(clk), .reset(reset), .sm_valid(sm_valid), .sm_set(sm_set), .sm_clr(sm_clr),
      .host_clr_wr(host_clr_wr), .host_clr_data(host_clr_data),
      .host_force_wr(host_force_wr), .host_force_data(host_force_data),
      .host_ovf_clr_wr(host_ovf_clr_wr), .host_ovf_clr_data(host_ovf_clr_data),
      .irq0_en(irq0_en), .irq1_en(irq1_en),
      .flags(flags), .overflow(overflow), .irq0(irq0), .irq1(irq1));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, req, $time);
      end
   endtask

   // Model: count set sources per bit and reason about each bit separately
   always @(posedge clk) begin
      if (reset) begin
         exp_flags = '0; exp_ovf = '0; exp_irq0 = 1'b0; exp_irq1 = 1'b0;
      end else begin
         logic [7:0] nf, no;
         for (int b = 0; b < 8; b++) begin
            int  nset;
            logic anyclr;
            nset   = (host_force_wr && host_force_data[b]) ? 1 : 0;
            anyclr = host_clr_wr && host_clr_data[b];
            for (int m = 0; m < NSM; m++)
               if (sm_valid[m]) begin
                  if (sm_set[8*m+b]) nset++;
                  if (sm_clr[8*m+b]) anyclr = 1'b1;
               end
            nf[b] = (nset > 0) ? 1'b1 : (anyclr ? 1'b0 : exp_flags[b]);
            if ((nset > 0 && exp_flags[b]) || nset > 1) no[b] = 1'b1;
            else if (host_ovf_clr_wr && host_ovf_clr_data[b]) no[b] = 1'b0;
            else no[b] = exp_ovf[b];
         end
         exp_irq0 = 1'b0; exp_irq1 = 1'b0;
         for (int b = 0; b < 4; b++) begin
            if (nf[b] && irq0_en[b]) exp_irq0 = 1'b1;
            if (nf[b] && irq1_en[b]) exp_irq1 = 1'b1;
         end
         exp_flags = nf; exp_ovf = no;
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_flags", flags, exp_flags);
         chk("model_ovf", overflow, exp_ovf);
         chk("model_irq0", {7'd0, irq0}, {7'd0, exp_irq0});
         chk("model_irq1", {7'd0, irq1}, {7'd0, exp_irq1});
      end
   end

   task automatic idle();
      reset = 1'b0; sm_valid = '0; sm_set = '0; sm_clr = '0;
      host_clr_wr = 1'b0; host_force_wr = 1'b0; host_ovf_clr_wr = 1'b0;
      host_clr_data = '0; host_force_data = '0; host_ovf_clr_data = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      idle();
      irq0_en = 4'h0; irq1_en = 4'h0;
      @(negedge clk);
      reset = 1'b1;
      cyc(); cyc();
      chk_on = 1'b1;
      reset = 1'b0;
      chk("reset_flags", flags, 8'h00);
      chk("reset_ovf", overflow, 8'h00);
      chk("reset_irq", {6'd0, irq1, irq0}, 8'h00);

      // SM0 sets flag 0
      irq0_en = 4'h1;
      sm_valid = 4'b0001; sm_set[7:0] = 8'h01;
      cyc(); idle();
      chk("set0_flags", flags, 8'h01);
      chk("set0_irq", {6'd0, irq1, irq0}, 8'h01);
      chk("set0_ovf", overflow, 8'h00);

      // Clear and set on same bit: set wins, overflow because already set
      sm_valid = 4'b0110; sm_clr[15:8] = 8'h01; sm_set[23:16] = 8'h01;
      cyc(); idle();
      chk("setwin_flags", flags, 8'h01);
      chk("setwin_ovf", overflow, 8'h01);

      // Overflow clear loses to a new overflow on the same bit
      host_ovf_clr_wr = 1'b1; host_ovf_clr_data = 8'h01;
      sm_valid = 4'b0001; sm_set[7:0] = 8'h01;
      cyc(); idle();
      chk("ovfclr_lose", overflow, 8'h01);

      // Clear everything while forcing flag 2
      host_clr_wr = 1'b1; host_clr_data = 8'hFF;
      host_ovf_clr_wr = 1'b1; host_ovf_clr_data = 8'hFF;
      host_force_wr = 1'b1; host_force_data = 8'h04;
      cyc(); idle();
      chk("force4_flags", flags, 8'h04);
      chk("force4_ovf", overflow, 8'h00);

      // Gated request is ignored
      sm_set[7:0] = 8'h04;
      cyc(); idle();
      chk("gated_flags", flags, 8'h04);
      chk("gated_ovf", overflow, 8'h00);

      // Upper flags never reach the interrupt lines
      irq0_en = 4'hF; irq1_en = 4'hF;
      host_clr_wr = 1'b1; host_clr_data = 8'hFF;
      cyc(); idle();
      host_force_wr = 1'b1; host_force_data = 8'h30;
      cyc(); idle();
      chk("force30_flags", flags, 8'h30);
      chk("force30_irq", {6'd0, irq1, irq0}, 8'h00);
      host_clr_wr = 1'b1; host_clr_data = 8'h10;
      cyc(); idle();
      chk("clr10_flags", flags, 8'h20);
      chk("clr10_irq", {6'd0, irq1, irq0}, 8'h00);

      // Two machines set flag 2 together
      host_clr_wr = 1'b1; host_clr_data = 8'hFF;
      cyc(); idle();
      sm_valid = 4'b1001; sm_set[7:0] = 8'h04; sm_set[31:24] = 8'h04;
      cyc(); idle();
      chk("multi_flags", flags, 8'h04);
      chk("multi_ovf", overflow, 8'h04);
      chk("multi_irq", {6'd0, irq1, irq0}, 8'h03);
      host_ovf_clr_wr = 1'b1; host_ovf_clr_data = 8'h04;
      cyc(); idle();
      chk("ovfclr_ovf", overflow, 8'h00);

      // Saturate then reset with a request pending
      host_force_wr = 1'b1; host_force_data = 8'hFF;
      cyc(); cyc(); idle();
      chk("sat_flags", flags, 8'hFF);
      chk("sat_ovf", overflow, 8'hFF);
      reset = 1'b1; sm_valid = 4'b0001; sm_set[7:0] = 8'h01;
      cyc(); idle();
      chk("rst2_flags", flags, 8'h00);
      chk("rst2_ovf", overflow, 8'h00);
      chk("rst2_irq", {6'd0, irq1, irq0}, 8'h00);

      // Mixed traffic checked against the model only
      for (int n = 0; n < 200; n++) begin
         sm_valid = 4'($urandom);
         sm_set = $urandom & $urandom;
         sm_clr = $urandom & $urandom;
         host_clr_wr = 1'($urandom_range(0, 3) == 0); host_clr_data = 8'($urandom);
         host_force_wr = 1'($urandom_range(0, 3) == 0); host_force_data = 8'($urandom);
         host_ovf_clr_wr = 1'($urandom_range(0, 2) == 0); host_ovf_clr_data = 8'($urandom);
         irq0_en = 4'($urandom); irq1_en = 4'($urandom);
         cyc();
      end
      idle();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pio_irq_ctrl.md
Name: pio_irq_ctrl

Overview:
- Owns the 8 shared PIO IRQ flags for the NUM_SM state machines in a PIO block.
- Merges per-machine set and clear requests with host write-1-to-clear and force writes into one registered flag vector.
- The flag vector drives every machine's irq_flags_in, which the machines use for WAIT IRQ and IRQ-set-wait.
- Drives two masked system interrupt lines from flags[3:0] and keeps sticky per-flag overflow status.

Parameters:
- NUM_SM, 4, number of state machines served (1..4)
- NUM_FLAGS, 8, number of IRQ flags (fixed at 8; lower flags 0..3 are system-visible)

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sm_valid  input  NUM_SM  machine i is executing an IRQ instruction this cycle (en & penable & !delaying)
- sm_set  input  NUM_SM*8  machine i set request vector, bits [8i+7:8i], index already resolved (REL applied)
- sm_clr  input  NUM_SM*8  machine i clear request vector, same packing
- host_clr_wr  input  1  host write strobe, write-1-to-clear flags
- host_clr_data  input  8  flags to clear on host_clr_wr
- host_force_wr  input  1  host write strobe, force-set flags
- host_force_data  input  8  flags to set on host_force_wr
- host_ovf_clr_wr  input  1  host write-1-to-clear of overflow bits
- host_ovf_clr_data  input  8  overflow bits to clear
- irq0_en  input  4  system interrupt 0 enable mask over flags[3:0]
- irq1_en  input  4  system interrupt 1 enable mask over flags[3:0]
- flags  output  8  registered flag vector, routed to all machines' irq_flags_in
- overflow  output  8  sticky: set request hit an already-set flag
- irq0  output  1  registered, |(flags[3:0] & irq0_en)
- irq1  output  1  registered, |(flags[3:0] & irq1_en)

Behaviour:
- Reset (synchronous): flags=0, overflow=0, irq0=0, irq1=0. Requests present in the reset cycle are discarded.
- Request gating: a machine's sm_set and sm_clr slices are ignored when its sm_valid bit is 0.
- Per-cycle merge:
  - set_any = OR over valid sm_set slices | (host_force_wr ? host_force_data : 0)
  - clr_any = OR over valid sm_clr slices | (host_clr_wr ? host_clr_data : 0)
  - flags_next = (flags & ~clr_any) | set_any
- Priority: set wins over clear on the same bit in the same cycle, whatever the source, so no event is lost. Different bits are independent.
- Latency:
  - flags updates one clock after a request.
  - A machine issuing IRQ SET with wait sees its own flag high on the next cycle and stalls until the flag reads 0.
  - irq0/irq1 are registered from flags_next, so they change in the same cycle as flags.
- Overflow: overflow[b] <= 1 when set_any[b] and flags[b] are both 1 (flag still set from before), or when more than one source sets b in the same cycle.
- Overflow clear: host_ovf_clr_wr clears the selected overflow bits. A new overflow condition in that same cycle wins.
- Multiple machines clearing or setting the same flag in one cycle is legal; the result is idempotent apart from overflow.
- Flags 4..7 never drive irq0/irq1. They are visible on flags and overflow only.
- NUM_SM < 4: unused request slices do not exist; no other behaviour changes.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then SM0 valid with sm_set=0x01 -> flags=0x01 next cycle; irq0=1 if irq0_en=0x1; overflow=0.
- flags=0x01; SM1 valid with sm_clr=0x01 while SM2 valid with sm_set=0x01, same cycle -> flags stays 0x01 (set wins); overflow[0]=1 because the flag was already set.
- flags=0x04; SM0 sm_set=0x04 with sm_valid=0 -> flags stays 0x04, overflow stays 0 (gated).
- Host force 0x30 then host clear 0x10 -> flags=0x30, then 0x20; irq0=irq1=0 throughout for any enables.
- SM0 and SM3 both set flag 2 in one cycle from flags=0 -> flags=0x04, overflow=0x04; host_ovf_clr 0x04 -> overflow=0x00.
- flags=0xFF, overflow=0xFF, assert reset while SM0 requests set=0x01 -> flags=0, overflow=0, irq0=irq1=0 the next cycle.
